// File: rtl/dm_pkg.sv
// Debug-module DMI payload types shared by the DTM, the CDC and anything
// sitting between them on the DMI channel.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_req_arb_pkg.sv
// Shared definitions for the DMI request arbiter: sequencer states and the
// response code returned to a requester after a timeout recovery.
package dmi_req_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CLEAR,
        ST_RESP
    } dmi_arb_state_e;

    localparam logic [1:0] DTM_ERR = 2'h2;

endpackage

// File: rtl/dmi_req_arb_timer.sv
// Up-counter with synchronous clear and count enable.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   clr_i         : force count to 0 (priority over en_i)
//   en_i          : advance count by one
//   expired_o     : count has reached Cycles-1; the counter holds there
module dmi_req_arb_timer #(
    parameter int unsigned Cycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = (Cycles > 1) ? $clog2(Cycles) : 1;
    localparam logic [W-1:0] LAST = W'(Cycles - 1);

    logic [W-1:0] r_cnt;

    assign expired_o = (r_cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && !expired_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmi_req_arb.sv
// Two-requester round-robin arbiter and single-outstanding sequencer for the
// DMI channel ahead of the DMI clock-domain crossing. A stalled crossing is
// recovered by pulsing the CDC clear and answering the owner with DTM_ERR.
//   clk_i / rst_ni              : tck, synchronous active-low reset
//   req_valid_i/req_ready_o/req_i : per-requester request handshake
//   resp_valid_o/resp_ready_i   : per-requester response handshake
//   resp_o                      : response payload (shared)
//   dmi_req_o/dmi_valid_o/dmi_ready_i  : request side of the CDC
//   dmi_resp_i/dmi_valid_i/dmi_ready_o : response side of the CDC
//   dmi_cdc_clear_o             : synchronous clear to the CDC
//   busy_o                      : sequencer not idle
//   timeout_cnt_o               : saturating count of timeouts
module dmi_req_arb
    import dmi_req_arb_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned ClearCycles   = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          req_valid_i,
    output logic [1:0]          req_ready_o,
    input  dm::dmi_req_t [1:0]  req_i,
    output logic [1:0]          resp_valid_o,
    input  logic [1:0]          resp_ready_i,
    output dm::dmi_resp_t       resp_o,
    output dm::dmi_req_t        dmi_req_o,
    output logic                dmi_valid_o,
    input  logic                dmi_ready_i,
    input  dm::dmi_resp_t       dmi_resp_i,
    input  logic                dmi_valid_i,
    output logic                dmi_ready_o,
    output logic                dmi_cdc_clear_o,
    output logic                busy_o,
    output logic [7:0]          timeout_cnt_o
);

    dmi_arb_state_e r_state;
    dm::dmi_req_t   r_req;
    dm::dmi_resp_t  r_resp;
    logic           r_owner;
    logic           r_last;
    logic           r_dmi_valid;
    logic           r_dmi_ready;
    logic           r_clear;
    logic [1:0]     r_resp_valid;
    logic           r_busy;
    logic [7:0]     r_tcnt;

    logic w_gnt;
    logic w_grant;
    logic w_tmo_exp;
    logic w_clr_exp;

    // On contention the requester that did not own the last transaction wins.
    assign w_gnt   = (req_valid_i == 2'b11) ? ~r_last : req_valid_i[1];
    assign w_grant = (r_state == ST_IDLE) && (|req_valid_i);

    assign req_ready_o = w_grant ? {w_gnt, ~w_gnt} : 2'b00;

    // Both timers restart on a grant; the clear timer only runs in CLEAR,
    // so it is still at zero when CLEAR is entered.
    dmi_req_arb_timer #(.Cycles(TimeoutCycles)) u_tmo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (w_grant),
        .en_i      ((r_state == ST_ISSUE) || (r_state == ST_WAIT)),
        .expired_o (w_tmo_exp)
    );

    dmi_req_arb_timer #(.Cycles(ClearCycles)) u_clr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (w_grant),
        .en_i      (r_state == ST_CLEAR),
        .expired_o (w_clr_exp)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_resp       <= '0;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_dmi_valid  <= 1'b0;
            r_dmi_ready  <= 1'b0;
            r_clear      <= 1'b0;
            r_resp_valid <= 2'b00;
            r_busy       <= 1'b0;
            r_tcnt       <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_req       <= req_i[w_gnt];
                        r_owner     <= w_gnt;
                        r_dmi_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    // A completing handshake beats a simultaneous timeout.
                    if (r_state == ST_ISSUE && dmi_ready_i) begin
                        r_dmi_valid <= 1'b0;
                        r_dmi_ready <= 1'b1;
                        r_state     <= ST_WAIT;
                    end else if (r_state == ST_WAIT && dmi_valid_i) begin
                        r_resp       <= dmi_resp_i;
                        r_dmi_ready  <= 1'b0;
                        r_resp_valid <= {r_owner, ~r_owner};
                        r_state      <= ST_RESP;
                    end else if (w_tmo_exp) begin
                        r_resp      <= '{data: 32'h0, resp: DTM_ERR};
                        r_dmi_valid <= 1'b0;
                        r_dmi_ready <= 1'b0;
                        r_clear     <= 1'b1;
                        if (r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
                        r_state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_exp) begin
                        r_clear      <= 1'b0;
                        r_resp_valid <= {r_owner, ~r_owner};
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i[r_owner]) begin
                        r_last       <= r_owner;
                        r_resp_valid <= 2'b00;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmi_req_o       = r_req;
    assign dmi_valid_o     = r_dmi_valid;
    assign dmi_ready_o     = r_dmi_ready;
    assign dmi_cdc_clear_o = r_clear;
    assign resp_valid_o    = r_resp_valid;
    assign resp_o          = r_resp;
    assign busy_o          = r_busy;
    assign timeout_cnt_o   = r_tcnt;

endmodule

// File: tb/tb_dmi_req_arb.sv
module tb_dmi_req_arb;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [1:0]         req_valid_i;
    logic [1:0]         req_ready_o;
    dm::dmi_req_t [1:0] req_i;
    logic [1:0]         resp_valid_o;
    logic [1:0]         resp_ready_i;
    dm::dmi_resp_t      resp_o;
    dm::dmi_req_t       dmi_req_o;
    logic               dmi_valid_o;
    logic               dmi_ready_i;
    dm::dmi_resp_t      dmi_resp_i;
    logic               dmi_valid_i;
    logic               dmi_ready_o;
    logic               dmi_cdc_clear_o;
    logic               busy_o;
    logic [7:0]         timeout_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    dmi_req_arb #(.TimeoutCycles(16), .ClearCycles(4)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_i           (req_i),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .resp_o          (resp_o),
        .dmi_req_o       (dmi_req_o),
        .dmi_valid_o     (dmi_valid_o),
        .dmi_ready_i     (dmi_ready_i),
        .dmi_resp_i      (dmi_resp_i),
        .dmi_valid_i     (dmi_valid_i),
        .dmi_ready_o     (dmi_ready_o),
        .dmi_cdc_clear_o (dmi_cdc_clear_o),
        .busy_o          (busy_o),
        .timeout_cnt_o   (timeout_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1:0] oh(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    // One transaction with a CDC that is ready at once and answers in WAIT.
    // Entered and left in an IDLE cycle; checks cycles 0..4 of the sequence.
    task automatic do_txn(input string tag, input logic [1:0] v, input logic eo,
                          input logic [31:0] rd);
        dm::dmi_resp_t er;
        er = '{data: rd, resp: 2'h0};
        req_valid_i = v;
        dmi_ready_i = 1'b1;
        #1;
        chk({tag, ".gnt"}, 64'(req_ready_o), 64'(oh(eo)));
        tick();
        chk({tag, ".dvld"}, 64'(dmi_valid_o), 64'(1));
        chk({tag, ".dreq"}, 64'(dmi_req_o), 64'(req_i[eo]));
        tick();
        chk({tag, ".drdy"}, 64'({dmi_ready_o, dmi_valid_o}), 64'(2'b10));
        dmi_valid_i = 1'b1;
        dmi_resp_i  = er;
        tick();
        dmi_valid_i = 1'b0;
        chk({tag, ".rvld"}, 64'(resp_valid_o), 64'(oh(eo)));
        chk({tag, ".resp"}, 64'(resp_o), 64'(er));
        resp_ready_i = oh(eo);
        tick();
        resp_ready_i = 2'b00;
        chk({tag, ".done"}, 64'({resp_valid_o, busy_o}), 64'(0));
        req_valid_i = 2'b00;
    endtask

    initial begin
        dm::dmi_resp_t err_r;
        logic          bad;
        err_r = '{data: 32'h0, resp: 2'h2};

        rst_ni       = 1'b0;
        req_valid_i  = 2'b00;
        resp_ready_i = 2'b00;
        dmi_ready_i  = 1'b0;
        dmi_valid_i  = 1'b0;
        dmi_resp_i   = '0;
        req_i[0]     = '{addr: 7'h10, op: dm::DTM_WRITE, data: 32'hDEADBEEF};
        req_i[1]     = '{addr: 7'h22, op: dm::DTM_NOP,   data: 32'hB1B1B1B1};
        tick();
        tick();
        rst_ni = 1'b1;
        chk("rst.outs", 64'({dmi_valid_o, dmi_ready_o, dmi_cdc_clear_o, resp_valid_o, busy_o}), 64'(0));
        chk("rst.tcnt", 64'(timeout_cnt_o), 64'(0));
        chk("rst.dreq", 64'(dmi_req_o), 64'(0));
        chk("rst.resp", 64'(resp_o), 64'(0));
        tick();

        // Single requester 0, minimum latency.
        do_txn("t1", 2'b01, 1'b0, 32'h1);

        // Contention: last owner was 0, so alternation starts with 1.
        req_i[0] = '{addr: 7'h11, op: dm::DTM_READ, data: 32'hA0A0A0A0};
        do_txn("t2a", 2'b11, 1'b1, 32'h100);
        do_txn("t2b", 2'b11, 1'b0, 32'h101);
        do_txn("t2c", 2'b11, 1'b1, 32'h102);
        do_txn("t2d", 2'b11, 1'b0, 32'h103);

        // Timeout in WAIT, requester 1.
        req_valid_i = 2'b10;
        dmi_ready_i = 1'b1;
        #1;
        chk("t3.gnt", 64'(req_ready_o), 64'(2'b10));
        tick();
        req_valid_i = 2'b00;
        tick();
        dmi_ready_i = 1'b0;
        repeat (14) tick();
        chk("t3.c16", 64'({dmi_ready_o, dmi_cdc_clear_o}), 64'(2'b10));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t3.clr%0d", i), 64'({dmi_cdc_clear_o, dmi_ready_o, dmi_valid_o}), 64'(3'b100));
        end
        tick();
        chk("t3.clr_end", 64'(dmi_cdc_clear_o), 64'(0));
        chk("t3.rvld", 64'(resp_valid_o), 64'(2'b10));
        chk("t3.resp", 64'(resp_o), 64'(err_r));
        chk("t3.tcnt", 64'(timeout_cnt_o), 64'(1));
        resp_ready_i = 2'b10;
        tick();
        resp_ready_i = 2'b00;

        // Timeout in ISSUE: CDC never ready.
        req_valid_i = 2'b01;
        dmi_ready_i = 1'b0;
        #1;
        chk("t4.gnt", 64'(req_ready_o), 64'(2'b01));
        tick();
        req_valid_i = 2'b00;
        repeat (15) tick();
        chk("t4.c16", 64'({dmi_valid_o, dmi_cdc_clear_o}), 64'(2'b10));
        tick();
        chk("t4.c17", 64'({dmi_valid_o, dmi_cdc_clear_o}), 64'(2'b01));
        repeat (3) tick();
        chk("t4.c20", 64'(dmi_cdc_clear_o), 64'(1));
        tick();
        chk("t4.rvld", 64'({resp_valid_o, dmi_cdc_clear_o}), 64'(3'b010));
        chk("t4.resp", 64'(resp_o), 64'(err_r));
        chk("t4.tcnt", 64'(timeout_cnt_o), 64'(2));
        resp_ready_i = 2'b01;
        tick();
        resp_ready_i = 2'b00;

        // Response on the exact timeout cycle wins.
        req_valid_i = 2'b01;
        dmi_ready_i = 1'b1;
        tick();
        req_valid_i = 2'b00;
        tick();
        dmi_ready_i = 1'b0;
        bad = dmi_cdc_clear_o;
        repeat (14) begin
            tick();
            bad = bad | dmi_cdc_clear_o;
        end
        chk("t5.c16", 64'(dmi_ready_o), 64'(1));
        dmi_valid_i = 1'b1;
        dmi_resp_i  = '{data: 32'hCAFE0005, resp: 2'h0};
        tick();
        dmi_valid_i = 1'b0;
        bad = bad | dmi_cdc_clear_o;
        chk("t5.noclr", 64'(bad), 64'(0));
        chk("t5.rvld", 64'(resp_valid_o), 64'(2'b01));
        chk("t5.resp", 64'(resp_o), 64'({32'hCAFE0005, 2'h0}));
        chk("t5.tcnt", 64'(timeout_cnt_o), 64'(2));
        resp_ready_i = 2'b01;
        tick();
        resp_ready_i = 2'b00;

        // Reset during WAIT drops the transaction.
        req_valid_i = 2'b10;
        dmi_ready_i = 1'b1;
        tick();
        req_valid_i = 2'b00;
        tick();
        chk("t6.wait", 64'(dmi_ready_o), 64'(1));
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("t6.outs", 64'({dmi_valid_o, dmi_ready_o, dmi_cdc_clear_o, resp_valid_o, busy_o}), 64'(0));
        chk("t6.tcnt", 64'(timeout_cnt_o), 64'(0));
        chk("t6.dreq", 64'(dmi_req_o), 64'(0));
        tick();
        chk("t6.norsp", 64'({resp_valid_o, busy_o}), 64'(0));
        // last_owner is back to 1, so requester 0 wins contention.
        do_txn("t6.post", 2'b11, 1'b0, 32'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_req_arb.md
# dmi_req_arb

Two-requester arbiter and transaction sequencer for the debug DMI channel on the JTAG side of the DMI clock-domain crossing. It shares one DMI request/response path between requester 0 (JTAG DTM) and requester 1 (secondary debug access port).
- Round-robin arbitration, one outstanding transaction at a time.
- Each response is routed back to its owner.
- A stalled crossing is recovered by timeout: the block pulses the CDC synchronous-clear input and returns an error response to the owner.

## Interface
Parameters:
- TimeoutCycles, 1024 — cycles allowed from issue to response before recovery (≥2)
- ClearCycles, 4 — cycles `dmi_cdc_clear_o` is held high during recovery (≥1)

Ports:
- clk_i  in  1  clock; same clock as the CDC write side (tck)
- rst_ni  in  1  reset; synchronous, active-low
- req_valid_i  in  [1:0]  per-requester request valid
- req_ready_o  out  [1:0]  per-requester request accept
- req_i  in  2×dm::dmi_req_t  per-requester request payload
- resp_valid_o  out  [1:0]  per-requester response valid
- resp_ready_i  in  [1:0]  per-requester response accept
- resp_o  out  dm::dmi_resp_t  response payload, shared by both requesters
- dmi_req_o  out  dm::dmi_req_t  request to CDC
- dmi_valid_o  out  1  request valid to CDC
- dmi_ready_i  in  1  CDC request ready
- dmi_resp_i  in  dm::dmi_resp_t  response from CDC
- dmi_valid_i  in  1  CDC response valid
- dmi_ready_o  out  1  response ready to CDC
- dmi_cdc_clear_o  out  1  synchronous clear to CDC
- busy_o  out  1  state ≠ IDLE
- timeout_cnt_o  out  8  saturating count of timeouts

## Operation
States: IDLE, ISSUE, WAIT, CLEAR, RESP.
- IDLE
  - Grant goes to the requester with `req_valid_i` set. If both are set, grant goes to the one not equal to `last_owner` (reset value 1, so requester 0 wins first).
  - In the grant cycle: `req_ready_o[g]`=1 combinationally, `req_i[g]` is captured into `req_q`, `owner_q`=g, next state ISSUE.
- ISSUE
  - `dmi_valid_o`=1 and `dmi_req_o`=`req_q`, both stable.
  - On `dmi_ready_i`, go to WAIT.
- WAIT
  - `dmi_ready_o`=1.
  - On `dmi_valid_i`, capture `dmi_resp_i` into `resp_q` and go to RESP.
- Timer
  - Clears on entry to ISSUE.
  - Increments every cycle in ISSUE and WAIT.
  - When the timer equals TimeoutCycles-1 and no completing handshake is present that cycle, go to CLEAR.
- CLEAR
  - `dmi_cdc_clear_o`=1 for exactly ClearCycles cycles.
  - `dmi_valid_o`=0 and `dmi_ready_o`=0.
  - Loads `resp_q`: data 0, resp = DTM_ERR (2'h2).
  - `timeout_cnt_o` increments, saturating at 255.
  - Then go to RESP.
- RESP
  - `resp_valid_o[owner_q]`=1 and `resp_o`=`resp_q`; the other bit is 0.
  - On `resp_ready_i[owner_q]`: `last_owner`=`owner_q`, go to IDLE.
- Requests of every op (including NOP) are forwarded unchanged.

## Timing
- Reset values (all outputs, except the combinational `req_ready_o`):
  - `req_q`, `resp_q`, `owner_q` = 0; `last_owner` = 1.
  - `dmi_valid_o`, `dmi_ready_o`, `dmi_cdc_clear_o`, `resp_valid_o`, `busy_o`, `timeout_cnt_o` = 0.
  - Reset in any state returns to IDLE next edge. The in-flight transaction is dropped with no response.
- All outputs except `req_ready_o` are registered or decoded from state.
- Minimum latency: grant at cycle 0, `dmi_valid_o` at 1 (ready same cycle), `dmi_ready_o` at 2 (CDC response same cycle), `resp_valid_o` at 3.
- Back-to-back: a new grant is possible in the cycle after the RESP handshake.
- `req_valid_i` may drop while not granted; there is no protocol error.
- Simultaneous response and timeout in WAIT: the response wins and CLEAR is not entered.
- Timeout in ISSUE (CDC never ready): same recovery path as timeout in WAIT.

## Structure
- `dmi_req_arb_pkg`: state enum (`dmi_arb_state_e`), constant DTM_ERR.
- Reuse `dm::dmi_req_t` / `dm::dmi_resp_t`.
- One sub-module, `dmi_req_arb_timer`: a counter with clear, enable and `expired_o`, parameterized by TimeoutCycles and $clog2 width. It is reused for the ClearCycles countdown.

## Test plan
- Requester 0 only; addr 0x10, op write, data 0xDEADBEEF; CDC ready immediately, response data 0x1 resp 0 two cycles later → `dmi_req_o` matches, `resp_valid_o`=2'b01 at cycle 3 with 0x1/0.
- Both requesters continuously valid for 4 transactions → grants in order 0,1,0,1; each response appears only on the owner's `resp_valid_o` bit.
- WAIT with no response, TimeoutCycles=16 → `dmi_cdc_clear_o` high exactly 4 cycles; owner receives data 0, resp 2; `timeout_cnt_o`=1.
- `dmi_ready_i` held 0, TimeoutCycles=16 → timeout from ISSUE gives the same error response; `dmi_valid_o` drops in CLEAR.
- Response arrives on the exact timeout cycle → normal response delivered; `dmi_cdc_clear_o` never asserts.
- `rst_ni` low for 1 cycle while in WAIT → state IDLE, all outputs at reset values, no `resp_valid_o`; next request is serviced normally.
